// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the keypad_io_b3 matrix keypad scanner.
package keypad_pkg;
    localparam int NCOLS = 4;
    localparam logic [4:0] CAND_NONE    = 5'h10;
    localparam logic [4:0] CAND_INVALID = 5'h1F;
    // Indexed by row*4+col.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };
    typedef enum logic {IDLE, HELD} db_state_e;
endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: small key-code FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == CW'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wp_q] = din;
        wp_d    = do_push ? (wp_q == AW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
        rp_d    = do_pop ? (rp_q == AW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        dout    = mem_q[rp_q];
        count   = cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/keypad_io_b3.sv
// keypad_io_b3: 4x4 matrix keypad scanner with whole-frame debounce and a CPU valid/ack handshake.
// Define KEYPAD_FIFO_EN to queue presses in a FIFO_DEPTH-entry FIFO instead of a single register.
module keypad_io_b3
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    input  logic       key_ack,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       overrun
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("keypad_io_b3: illegal parameter value");
    end

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    c_q, c_d;
    logic [15:0]   keys_q, keys_d, frame;
    logic [3:0]    hit;
    logic [4:0]    cand, prev_q, prev_d, stable_cand;
    logic [CW-1:0] cnt_q, cnt_d;
    db_state_e     state_q, state_d;
    logic [3:0]    stable_q, stable_d;
    logic          push_q, push_d;
    logic [3:0]    push_code_q, push_code_d;
    logic          tick, frame_end;

    // The current column's rows are merged in so the frame-end tick sees all 16 keys at once.
    always_comb begin
        tick      = div_q == DW'(SCAN_DIV - 1);
        frame_end = tick && c_q == 2'(NCOLS - 1);
        div_d     = tick ? '0 : div_q + 1'b1;
        c_d       = tick ? c_q + 2'd1 : c_q;
        frame     = keys_q;
        for (int r = 0; r < 4; r++) frame[{2'(r), c_q}] = ~row_s2_q[2'(r)];
        keys_d    = tick ? frame : keys_q;
        hit       = '0;
        for (int i = 0; i < 16; i++) if (frame[4'(i)]) hit = 4'(i);
        cand      = frame == '0 ? CAND_NONE : $countones(frame) == 1 ? {1'b0, hit} : CAND_INVALID;
    end

    always_comb begin
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        stable_d    = stable_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
        stable_cand = state_q == HELD ? {1'b0, stable_q} : CAND_NONE;
        if (frame_end) begin
            if (cand == CAND_INVALID) begin
                prev_d = cand;
                cnt_d  = '0;
            end else if (cand == prev_q) begin
                cnt_d = cnt_q == CW'(DEBOUNCE_FRAMES) ? cnt_q : cnt_q + 1'b1;
            end else begin
                prev_d = cand;
                cnt_d  = CW'(1);
            end
            // A direct key-to-key change is a roll-over and emits a fresh press.
            if (cnt_d == CW'(DEBOUNCE_FRAMES) && cand != stable_cand) begin
                state_d     = cand[4] ? IDLE : HELD;
                stable_d    = cand[3:0];
                push_d      = !cand[4];
                push_code_d = KEY_MAP[cand[3:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            div_q       <= '0;
            c_q         <= '0;
            keys_q      <= '0;
            prev_q      <= CAND_NONE;
            cnt_q       <= '0;
            state_q     <= IDLE;
            stable_q    <= '0;
            push_q      <= 1'b0;
            push_code_q <= '0;
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            div_q       <= div_d;
            c_q         <= c_d;
            keys_q      <= keys_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            stable_q    <= stable_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
        end
    end

    assign col      = ~(4'b0001 << c_q);
    assign key_down = state_q == HELD;

`ifdef KEYPAD_FIFO_EN
    logic [3:0]                        head, last_q, last_d;
    logic                              full, empty, ovr_q, ovr_d;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;

    keypad_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (key_ack),
        .din   (push_code_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        last_d = empty ? last_q : head;
        ovr_d  = push_q && full && !key_ack ? 1'b1 : key_ack && !empty ? 1'b0 : ovr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            ovr_q  <= ovr_d;
        end
    end

    assign key_valid = fifo_count != '0;
    assign key_code  = empty ? last_q : head;
    assign overrun   = ovr_q;
`else
    logic       kv_q, kv_d, ovr_q, ovr_d;
    logic [3:0] code_q, code_d;

    always_comb begin
        kv_d   = push_q || (kv_q && !key_ack);
        code_d = push_q && (!kv_q || key_ack) ? push_code_q : code_q;
        ovr_d  = push_q && kv_q && !key_ack ? 1'b1 : key_ack && kv_q ? 1'b0 : ovr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kv_q   <= 1'b0;
            ovr_q  <= 1'b0;
            code_q <= '0;
        end else begin
            kv_q   <= kv_d;
            ovr_q  <= ovr_d;
            code_q <= code_d;
        end
    end

    assign key_valid = kv_q;
    assign key_code  = code_q;
    assign overrun   = ovr_q;
`endif
endmodule
